// File: rtl/axi_scratchpad_slave.sv
// AXI4 slave backed by a byte-writable word array; read and write channels each hold one
// transaction in flight. Define AXI_SCRATCHPAD_WRAP_EN to accept WRAP bursts.
module axi_scratchpad_slave #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned ID_WIDTH  = 2
) (
    input  logic                sys_clock_i,
    input  logic                sys_reset_i,
    input  logic [ID_WIDTH-1:0] s_axi_awid,
    input  logic [31:0]         s_axi_awaddr,
    input  logic [7:0]          s_axi_awlen,
    input  logic [2:0]          s_axi_awsize,
    input  logic [1:0]          s_axi_awburst,
    input  logic                s_axi_awlock,
    input  logic [3:0]          s_axi_awcache,
    input  logic [2:0]          s_axi_awprot,
    input  logic [3:0]          s_axi_awqos,
    input  logic [3:0]          s_axi_awregion,
    input  logic                s_axi_awvalid,
    output logic                s_axi_awready,
    input  logic [31:0]         s_axi_wdata,
    input  logic [3:0]          s_axi_wstrb,
    input  logic                s_axi_wlast,
    input  logic                s_axi_wvalid,
    output logic                s_axi_wready,
    output logic [ID_WIDTH-1:0] s_axi_bid,
    output logic [1:0]          s_axi_bresp,
    output logic                s_axi_bvalid,
    input  logic                s_axi_bready,
    input  logic [ID_WIDTH-1:0] s_axi_arid,
    input  logic [31:0]         s_axi_araddr,
    input  logic [7:0]          s_axi_arlen,
    input  logic [2:0]          s_axi_arsize,
    input  logic [1:0]          s_axi_arburst,
    input  logic                s_axi_arlock,
    input  logic [3:0]          s_axi_arcache,
    input  logic [2:0]          s_axi_arprot,
    input  logic [3:0]          s_axi_arqos,
    input  logic [3:0]          s_axi_arregion,
    input  logic                s_axi_arvalid,
    output logic                s_axi_arready,
    output logic [ID_WIDTH-1:0] s_axi_rid,
    output logic [31:0]         s_axi_rdata,
    output logic [1:0]          s_axi_rresp,
    output logic                s_axi_rlast,
    output logic                s_axi_rvalid,
    input  logic                s_axi_rready
);

    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam logic [31:0] SPAN   = 32'(DEPTH) * 32'd4;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;
`ifdef AXI_SCRATCHPAD_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_e;

    function automatic logic burst_err_f(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
        logic bad;
        case (burst)
            2'b00, 2'b01: bad = 1'b0;
            2'b10:        bad = !(WRAP_EN && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
            default:      bad = 1'b1;
        endcase
        return (size > 3'd2) || bad;
    endfunction

    // The wrap arithmetic runs even when WRAP is disabled; such bursts are errored anyway.
    function automatic logic [31:0] next_addr_f(input logic [31:0] addr, input logic [2:0] size,
                                                input logic [7:0] len, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] mask;
        logic [31:0] res;
        step = 32'd1 << size;
        mask = ((32'(len) + 32'd1) << size) - 32'd1;
        case (burst)
            2'b01:   res = addr + step;
            2'b10:   res = (addr & ~mask) | ((addr + step) & mask);
            default: res = addr;
        endcase
        return res;
    endfunction

    function automatic logic in_range_f(input logic [31:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    logic [31:0] mem_q [DEPTH];

    wstate_e             wstate_q, wstate_d;
    logic [ID_WIDTH-1:0] aw_id_q, aw_id_d;
    logic [31:0]         w_addr_q, w_addr_d;
    logic [7:0]          aw_len_q, aw_len_d, w_beat_q, w_beat_d;
    logic [2:0]          aw_size_q, aw_size_d;
    logic [1:0]          aw_burst_q, aw_burst_d, bresp_q, bresp_d;
    logic                w_berr_q, w_berr_d, w_err_q, w_err_d;
    logic                awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic                aw_hs_s, w_hs_s, b_hs_s, w_beat_err_s, w_last_beat_s, mem_we_s;
    logic [IDX_W-1:0]    w_idx_s;

    rstate_e             rstate_q, rstate_d;
    logic [ID_WIDTH-1:0] rid_q, rid_d;
    logic [31:0]         r_addr_q, r_addr_d, rdata_q, rdata_d, rd_addr_s;
    logic [7:0]          ar_len_q, ar_len_d, r_beat_q, r_beat_d, rd_len_s, rd_beat_s;
    logic [2:0]          ar_size_q, ar_size_d, rd_size_s;
    logic [1:0]          ar_burst_q, ar_burst_d, rd_burst_s, rresp_q, rresp_d;
    logic                r_berr_q, r_berr_d, rd_berr_s, rd_err_s, rd_load_s;
    logic                arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic                ar_hs_s, r_hs_s;
    logic [IDX_W-1:0]    r_idx_s;
    logic                unused_s;

    assign unused_s = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos, s_axi_awregion,
                        s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos, s_axi_arregion};

    assign aw_hs_s       = s_axi_awvalid && awready_q;
    assign w_hs_s        = s_axi_wvalid && wready_q;
    assign b_hs_s        = bvalid_q && s_axi_bready;
    assign w_beat_err_s  = w_berr_q || !in_range_f(w_addr_q);
    assign w_last_beat_s = (w_beat_q == aw_len_q);
    assign mem_we_s      = w_hs_s && !w_beat_err_s;
    assign w_idx_s       = IDX_W'((w_addr_q - BASE_ADDR) >> 2'd2);

    // Write channel state and datapath registers.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            wstate_q   <= W_IDLE;
            aw_id_q    <= '0;
            w_addr_q   <= 32'd0;
            aw_len_q   <= 8'd0;
            w_beat_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            bresp_q    <= 2'd0;
            w_berr_q   <= 1'b0;
            w_err_q    <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
        end else begin
            wstate_q   <= wstate_d;
            aw_id_q    <= aw_id_d;
            w_addr_q   <= w_addr_d;
            aw_len_q   <= aw_len_d;
            w_beat_q   <= w_beat_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            bresp_q    <= bresp_d;
            w_berr_q   <= w_berr_d;
            w_err_q    <= w_err_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
        end
    end

    // Write channel next state.
    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            W_IDLE:  if (aw_hs_s) wstate_d = W_DATA; else wstate_d = W_IDLE;
            W_DATA:  if (w_hs_s && w_last_beat_s) wstate_d = W_RESP; else wstate_d = W_DATA;
            W_RESP:  if (b_hs_s) wstate_d = W_IDLE; else wstate_d = W_RESP;
            default: wstate_d = W_IDLE;
        endcase
    end

    // Write channel outputs and burst bookkeeping.
    always_comb begin
        awready_d  = (wstate_d == W_IDLE);
        wready_d   = (wstate_d == W_DATA);
        bvalid_d   = (wstate_d == W_RESP);
        aw_id_d    = aw_id_q;
        w_addr_d   = w_addr_q;
        aw_len_d   = aw_len_q;
        w_beat_d   = w_beat_q;
        aw_size_d  = aw_size_q;
        aw_burst_d = aw_burst_q;
        bresp_d    = bresp_q;
        w_berr_d   = w_berr_q;
        w_err_d    = w_err_q;
        if (aw_hs_s) begin
            aw_id_d    = s_axi_awid;
            w_addr_d   = s_axi_awaddr;
            aw_len_d   = s_axi_awlen;
            aw_size_d  = s_axi_awsize;
            aw_burst_d = s_axi_awburst;
            w_berr_d   = burst_err_f(s_axi_awsize, s_axi_awburst, s_axi_awlen);
            w_beat_d   = 8'd0;
            w_err_d    = 1'b0;
        end else if (w_hs_s) begin
            w_beat_d = w_beat_q + 8'd1;
            w_addr_d = next_addr_f(w_addr_q, aw_size_q, aw_len_q, aw_burst_q);
            w_err_d  = w_err_q || w_beat_err_s || (s_axi_wlast != w_last_beat_s);
            if (w_last_beat_s) bresp_d = w_err_d ? SLVERR : OKAY;
            else               bresp_d = bresp_q;
        end else begin
            w_err_d = w_err_q;
        end
    end

    // Byte-enabled array write; the array itself is not reset.
    always_ff @(posedge sys_clock_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (s_axi_wstrb[b]) mem_q[w_idx_s][8*b +: 8] <= s_axi_wdata[8*b +: 8];
            end
        end
    end

    assign ar_hs_s = s_axi_arvalid && arready_q;
    assign r_hs_s  = rvalid_q && s_axi_rready;

    // Read channel state and datapath registers.
    always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
        if (sys_reset_i) begin
            rstate_q   <= R_IDLE;
            rid_q      <= '0;
            r_addr_q   <= 32'd0;
            rdata_q    <= 32'd0;
            ar_len_q   <= 8'd0;
            r_beat_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            rresp_q    <= 2'd0;
            r_berr_q   <= 1'b0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rlast_q    <= 1'b0;
        end else begin
            rstate_q   <= rstate_d;
            rid_q      <= rid_d;
            r_addr_q   <= r_addr_d;
            rdata_q    <= rdata_d;
            ar_len_q   <= ar_len_d;
            r_beat_q   <= r_beat_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            rresp_q    <= rresp_d;
            r_berr_q   <= r_berr_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rlast_q    <= rlast_d;
        end
    end

    // Read channel next state.
    always_comb begin
        rstate_d = rstate_q;
        case (rstate_q)
            R_IDLE:  if (ar_hs_s) rstate_d = R_DATA; else rstate_d = R_IDLE;
            R_DATA:  if (r_hs_s && rlast_q) rstate_d = R_IDLE; else rstate_d = R_DATA;
            default: rstate_d = R_IDLE;
        endcase
    end

    // Read channel outputs; a beat is loaded on AR acceptance and after each non-final R handshake.
    always_comb begin
        arready_d  = (rstate_d == R_IDLE);
        rvalid_d   = (rstate_d == R_DATA);
        rid_d      = rid_q;
        r_addr_d   = r_addr_q;
        rdata_d    = rdata_q;
        ar_len_d   = ar_len_q;
        r_beat_d   = r_beat_q;
        ar_size_d  = ar_size_q;
        ar_burst_d = ar_burst_q;
        rresp_d    = rresp_q;
        r_berr_d   = r_berr_q;
        rlast_d    = rlast_q;
        rd_addr_s  = r_addr_q;
        rd_len_s   = ar_len_q;
        rd_size_s  = ar_size_q;
        rd_burst_s = ar_burst_q;
        rd_berr_s  = r_berr_q;
        rd_beat_s  = r_beat_q + 8'd1;
        rd_load_s  = 1'b0;
        if (ar_hs_s) begin
            rd_addr_s  = s_axi_araddr;
            rd_len_s   = s_axi_arlen;
            rd_size_s  = s_axi_arsize;
            rd_burst_s = s_axi_arburst;
            rd_berr_s  = burst_err_f(s_axi_arsize, s_axi_arburst, s_axi_arlen);
            rd_beat_s  = 8'd0;
            rd_load_s  = 1'b1;
            rid_d      = s_axi_arid;
            ar_len_d   = s_axi_arlen;
            ar_size_d  = s_axi_arsize;
            ar_burst_d = s_axi_arburst;
            r_berr_d   = rd_berr_s;
        end else if (r_hs_s && !rlast_q) begin
            rd_load_s = 1'b1;
        end else begin
            rd_load_s = 1'b0;
        end
        rd_err_s = rd_berr_s || !in_range_f(rd_addr_s);
        r_idx_s  = IDX_W'((rd_addr_s - BASE_ADDR) >> 2'd2);
        if (rd_load_s) begin
            rdata_d  = rd_err_s ? 32'd0 : mem_q[r_idx_s];
            rresp_d  = rd_err_s ? SLVERR : OKAY;
            rlast_d  = (rd_beat_s == rd_len_s);
            r_beat_d = rd_beat_s;
            r_addr_d = next_addr_f(rd_addr_s, rd_size_s, rd_len_s, rd_burst_s);
        end else if (r_hs_s) begin
            rlast_d = 1'b0;
        end else begin
            rlast_d = rlast_q;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_bid     = aw_id_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rlast   = rlast_q;
    assign s_axi_rid     = rid_q;

endmodule

// File: tb/tb_axi_scratchpad_slave.sv
// Directed bench for axi_scratchpad_slave: a table of single-beat accesses plus burst,
// wrap, out-of-range and mid-burst reset sequences.
module tb_axi_scratchpad_slave;

    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
    logic [31:0] s_axi_awaddr, s_axi_araddr, s_axi_wdata, s_axi_rdata;
    logic [7:0]  s_axi_awlen, s_axi_arlen;
    logic [2:0]  s_axi_awsize, s_axi_arsize;
    logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
    logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
    logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    axi_scratchpad_slave #(.BASE_ADDR(BASE), .DEPTH(256), .ID_WIDTH(2)) dut (
        .sys_clock_i(clk), .sys_reset_i(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
        .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0), .s_axi_awregion(4'd0),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
        .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0), .s_axi_arregion(4'd0),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic aw_send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        while (s_axi_awready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("awready_wait", 32'(s_axi_awready), 32'd1);
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (s_axi_wready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("wready_wait", 32'(s_axi_wready), 32'd1);
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic b_recv(input string nm, input logic [1:0] id, input logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (s_axi_bvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check({nm, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        check({nm, "_bresp"}, 32'(s_axi_bresp), 32'(resp));
        check({nm, "_bid"}, 32'(s_axi_bid), 32'(id));
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [1:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        while (s_axi_arready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check("arready_wait", 32'(s_axi_arready), 32'd1);
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic r_recv(input string nm, input logic [1:0] id, input logic [31:0] data,
                          input logic [1:0] resp, input logic last);
        int n = 0;
        s_axi_rready = 1'b1;
        while (s_axi_rvalid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        check({nm, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        check({nm, "_rdata"}, s_axi_rdata, data);
        check({nm, "_rresp"}, 32'(s_axi_rresp), 32'(resp));
        check({nm, "_rid"}, 32'(s_axi_rid), 32'(id));
        check({nm, "_rlast"}, 32'(s_axi_rlast), 32'(last));
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic wr_single(input string nm, input logic [1:0] id, input logic [31:0] addr,
                             input logic [31:0] data, input logic [1:0] resp);
        aw_send(id, addr, 8'd0, 3'd2, 2'b01);
        w_send(data, 4'hF, 1'b1);
        b_recv(nm, id, resp);
    endtask

    initial begin
        logic [31:0] wrap_data [4];
        logic [31:0] wrap_exp [4];
        logic [31:0] wrap_addr [4];
        logic [1:0]  wrap_resp;
        int          beat;

        vecs[0]  = '{1'b1, BASE + 32'h010, 3'd2, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, BASE + 32'h010, 3'd2, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, BASE + 32'h010, 3'd2, 32'h77000000, 4'h8, 2'b00, 32'h0};
        vecs[3]  = '{1'b0, BASE + 32'h010, 3'd2, 32'h0,        4'h0, 2'b00, 32'h77ADBEEF};
        vecs[4]  = '{1'b1, BASE + 32'h020, 3'd2, 32'h11223344, 4'hF, 2'b00, 32'h0};
        vecs[5]  = '{1'b1, BASE + 32'h020, 3'd2, 32'hAABBCCDD, 4'h5, 2'b00, 32'h0};
        vecs[6]  = '{1'b0, BASE + 32'h020, 3'd2, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
        vecs[7]  = '{1'b1, BASE + 32'h020, 3'd3, 32'h0BADF00D, 4'hF, 2'b10, 32'h0};
        vecs[8]  = '{1'b0, BASE + 32'h020, 3'd2, 32'h0,        4'h0, 2'b00, 32'h11BB33DD};
        vecs[9]  = '{1'b0, BASE + 32'h020, 3'd3, 32'h0,        4'h0, 2'b10, 32'h0};
        vecs[10] = '{1'b1, BASE + 32'h3FC, 3'd2, 32'hCAFEF00D, 4'hF, 2'b00, 32'h0};
        vecs[11] = '{1'b0, BASE + 32'h3FC, 3'd2, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        vecs[12] = '{1'b1, BASE + 32'h000, 3'd2, 32'h55AA55AA, 4'hF, 2'b00, 32'h0};
        vecs[13] = '{1'b1, BASE + 32'h400, 3'd2, 32'h12345678, 4'hF, 2'b10, 32'h0};
        vecs[14] = '{1'b1, BASE - 32'h004, 3'd2, 32'h99999999, 4'hF, 2'b10, 32'h0};
        vecs[15] = '{1'b0, BASE + 32'h000, 3'd2, 32'h0,        4'h0, 2'b00, 32'h55AA55AA};
        vecs[16] = '{1'b0, BASE + 32'h3FC, 3'd2, 32'h0,        4'h0, 2'b00, 32'hCAFEF00D};
        vecs[17] = '{1'b0, BASE + 32'h400, 3'd2, 32'h0,        4'h0, 2'b10, 32'h0};

        rst = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        s_axi_awid = 2'd0; s_axi_awaddr = 32'd0; s_axi_awlen = 8'd0; s_axi_awsize = 3'd0;
        s_axi_awburst = 2'd0; s_axi_wdata = 32'd0; s_axi_wstrb = 4'd0; s_axi_wlast = 1'b0;
        s_axi_arid = 2'd0; s_axi_araddr = 32'd0; s_axi_arlen = 8'd0; s_axi_arsize = 3'd0;
        s_axi_arburst = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", 32'(s_axi_awready), 32'd0);
        check("rst_arready", 32'(s_axi_arready), 32'd0);
        check("rst_wready", 32'(s_axi_wready), 32'd0);
        check("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
        check("rst_rlast", 32'(s_axi_rlast), 32'd0);
        check("rst_outs", {s_axi_rdata[29:0], s_axi_bresp}, 32'd0);
        check("rst_ids", {26'd0, s_axi_rresp, s_axi_bid, s_axi_rid}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_awready", 32'(s_axi_awready), 32'd1);
        check("post_rst_arready", 32'(s_axi_arready), 32'd1);

        // Single-beat table; one-cycle latency of wready, bvalid and rvalid checked inline.
        for (int i = 0; i < 18; i++) begin
            logic [1:0] id;
            id = 2'(i);
            if (vecs[i].wr) begin
                aw_send(id, vecs[i].addr, 8'd0, vecs[i].size, 2'b01);
                check($sformatf("vec%0d_wready_lat", i), 32'(s_axi_wready), 32'd1);
                w_send(vecs[i].wdata, vecs[i].strb, 1'b1);
                check($sformatf("vec%0d_bvalid_lat", i), 32'(s_axi_bvalid), 32'd1);
                b_recv($sformatf("vec%0d", i), id, vecs[i].resp);
            end else begin
                ar_send(id, vecs[i].addr, 8'd0, vecs[i].size, 2'b01);
                check($sformatf("vec%0d_rvalid_lat", i), 32'(s_axi_rvalid), 32'd1);
                r_recv($sformatf("vec%0d", i), id, vecs[i].rdata, vecs[i].resp, 1'b1);
            end
        end

        // INCR len=3 write, then read back with rready toggling every cycle.
        aw_send(2'd1, BASE, 8'd3, 3'd2, 2'b01);
        for (int k = 0; k < 4; k++) w_send(32'(k + 1), 4'hF, (k == 3));
        b_recv("incr_wr", 2'd1, 2'b00);
        ar_send(2'd2, BASE, 8'd3, 3'd2, 2'b01);
        beat = 0;
        for (int c = 0; c < 40 && beat < 4; c++) begin
            check("incr_rvalid", 32'(s_axi_rvalid), 32'd1);
            check("incr_rdata", s_axi_rdata, 32'(beat + 1));
            check("incr_rlast", 32'(s_axi_rlast), 32'(beat == 3));
            s_axi_rready = ~s_axi_rready;
            if (s_axi_rvalid && s_axi_rready) beat++;
            @(posedge clk); #1;
        end
        s_axi_rready = 1'b0;
        check("incr_beats", 32'(beat), 32'd4);
        check("incr_rvalid_end", 32'(s_axi_rvalid), 32'd0);

        // Read running off the top of the array: second beat errors.
        ar_send(2'd0, BASE + 32'h3FC, 8'd1, 3'd2, 2'b01);
        r_recv("oor_b0", 2'd0, 32'hCAFEF00D, 2'b00, 1'b0);
        r_recv("oor_b1", 2'd0, 32'h0, 2'b10, 1'b1);

        // WRAP len=3 starting at BASE+0x08 over words holding 1,2,3,4.
        wrap_data[0] = 32'hA0; wrap_data[1] = 32'hA1; wrap_data[2] = 32'hA2; wrap_data[3] = 32'hA3;
        wrap_addr[0] = BASE + 32'h8; wrap_addr[1] = BASE + 32'hC;
        wrap_addr[2] = BASE + 32'h0; wrap_addr[3] = BASE + 32'h4;
`ifdef AXI_SCRATCHPAD_WRAP_EN
        wrap_resp = 2'b00;
        for (int k = 0; k < 4; k++) wrap_exp[k] = wrap_data[k];
`else
        wrap_resp = 2'b10;
        wrap_exp[0] = 32'd3; wrap_exp[1] = 32'd4; wrap_exp[2] = 32'd1; wrap_exp[3] = 32'd2;
`endif
        aw_send(2'd3, BASE + 32'h8, 8'd3, 3'd2, 2'b10);
        for (int k = 0; k < 4; k++) w_send(wrap_data[k], 4'hF, (k == 3));
        b_recv("wrap_wr", 2'd3, wrap_resp);
        for (int k = 0; k < 4; k++) begin
            ar_send(2'd1, wrap_addr[k], 8'd0, 3'd2, 2'b01);
            r_recv($sformatf("wrap_word%0d", k), 2'd1, wrap_exp[k], 2'b00, 1'b1);
        end
        ar_send(2'd2, BASE + 32'h8, 8'd3, 3'd2, 2'b10);
        for (int k = 0; k < 4; k++) begin
            r_recv($sformatf("wrap_rd%0d", k), 2'd2,
                   (wrap_resp == 2'b00) ? wrap_data[k] : 32'd0, wrap_resp, (k == 3));
        end

        // Reset during beat 2 of a len=7 write.
        aw_send(2'd1, BASE + 32'h80, 8'd7, 3'd2, 2'b01);
        w_send(32'h100, 4'hF, 1'b0);
        w_send(32'h101, 4'hF, 1'b0);
        s_axi_wdata = 32'h102; s_axi_wvalid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_awready", 32'(s_axi_awready), 32'd0);
        check("midrst_wready", 32'(s_axi_wready), 32'd0);
        check("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check("midrst_arready", 32'(s_axi_arready), 32'd0);
        check("midrst_bid", 32'(s_axi_bid), 32'd0);
        s_axi_wvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_awready_after", 32'(s_axi_awready), 32'd1);
        check("midrst_bvalid_after", 32'(s_axi_bvalid), 32'd0);
        ar_send(2'd0, BASE + 32'h80, 8'd1, 3'd2, 2'b01);
        r_recv("midrst_partial0", 2'd0, 32'h100, 2'b00, 1'b0);
        r_recv("midrst_partial1", 2'd0, 32'h101, 2'b00, 1'b1);
        wr_single("midrst_new_wr", 2'd2, BASE + 32'h88, 32'hFEEDFACE, 2'b00);
        ar_send(2'd3, BASE + 32'h88, 8'd0, 3'd2, 2'b01);
        r_recv("midrst_new_rd", 2'd3, 32'hFEEDFACE, 2'b00, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
